// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte over the
// open-drain clock/data pair and reports completion, missing ACK or timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | both lines released, waiting for start_i
// INHIBIT   | clock held low; start bit asserted in the last cycle
// RELEASE   | clock released, start bit held, timeout armed
// SEND      | shift D0..D7, parity, stop on device clock falling edges
// ACK       | sample the device ACK on the next falling edge
// WAIT_IDLE | wait for both lines high, then report done
module ps2_host_tx #(
    parameter int unsigned FREQ_HZ        = 25_000_000,
    parameter int unsigned INHIBIT_CYCLES = FREQ_HZ / 10_000,
    parameter int unsigned TIMEOUT_CYCLES = FREQ_HZ / 500
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       ps2clk_i,
    input  logic       ps2dat_i,
    output logic       ps2clk_low_o,
    output logic       ps2dat_low_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [TW-1:0] TMR_ZERO = '0;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [2:0]    state_q,   state_d;
    logic [TW-1:0] tmr_q,     tmr_d;
    logic [3:0]    bitcnt_q,  bitcnt_d;
    logic [8:0]    shift_q,   shift_d;
    logic          clk_low_q, clk_low_d;
    logic          dat_low_q, dat_low_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic          err_q,     err_d;
    logic          ack_ok_q,  ack_ok_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q, dat_prev_q;

    logic clk_fe;
    logic line_idle;
    logic tmr_active;
    logic tmr_expired;

    // Sync FFs reset to 1 so an idle (pulled-up) bus never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            dat_prev_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2clk_i;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2dat_i;
            dat_sync_q <= dat_meta_q;
            dat_prev_q <= dat_sync_q;
        end
    end

    assign clk_fe      = clk_prev_q & ~clk_sync_q;
    // Bus counts as idle only once both lines have been high for two samples.
    assign line_idle   = clk_sync_q & clk_prev_q & dat_sync_q & dat_prev_q;
    assign tmr_active  = (state_q == S_RELEASE) || (state_q == S_SEND) ||
                         (state_q == S_ACK)     || (state_q == S_WAIT_IDLE);
    assign tmr_expired = tmr_active && (tmr_q == TMR_ZERO);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        clk_low_d = clk_low_q;
        dat_low_d = dat_low_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        ack_ok_d  = ack_ok_q;

        case (state_q)
            S_IDLE: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                if (start_i) begin
                    shift_d   = {~^data_i, data_i};
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    ack_ok_d  = 1'b0;
                    clk_low_d = 1'b1;
                    tmr_d     = INH_LOAD;
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (tmr_q <= TMR_ONE) begin
                    dat_low_d = 1'b1;
                end
                if (tmr_q == TMR_ZERO) begin
                    clk_low_d = 1'b0;
                    tmr_d     = TMO_LOAD;
                    bitcnt_d  = 4'd0;
                    state_d   = S_RELEASE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end

            S_RELEASE: begin
                state_d = S_SEND;
            end

            S_SEND: begin
                if (clk_fe) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        dat_low_d = 1'b0;
                        state_d   = S_ACK;
                    end else begin
                        dat_low_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                    end
                end
            end

            S_ACK: begin
                if (clk_fe) begin
                    ack_ok_d = ~dat_sync_q;
                    state_d  = S_WAIT_IDLE;
                end
            end

            S_WAIT_IDLE: begin
                if (line_idle) begin
                    done_d  = 1'b1;
                    err_d   = ~ack_ok_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // Timeout overrides any frame event decided above.
        if (tmr_active) begin
            if (tmr_expired) begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                done_d    = 1'b1;
                err_d     = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end else begin
                tmr_d = tmr_q - TMR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            bitcnt_q  <= 4'd0;
            shift_q   <= 9'd0;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            clk_low_q <= clk_low_d;
            dat_low_q <= dat_low_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ack_ok_q  <= ack_ok_d;
        end
    end

    assign ps2clk_low_o = clk_low_q;
    assign ps2dat_low_o = dat_low_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
